// File: rtl/osd_sdm_event_monitor.sv
// Multi-channel memory-write event monitor: address-window match, timestamped
// event FIFO, overflow drop counting and 16-bit flit packet serialisation.
module osd_sdm_event_monitor #(
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_WIDTH   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_request,
  input  logic        reg_write,
  input  logic [15:0] reg_addr,
  input  logic [15:0] reg_wdata,
  output logic        reg_ack,
  output logic        reg_err,
  output logic [15:0] reg_rdata,
  input  logic        mem_valid,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  output logic [15:0] out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready
);

  // state   | meaning
  // IDLE    | no packet in flight
  // HDR     | header flit {lost, 0, ch}
  // ADDR_HI | address [31:16]
  // ADDR_LO | address [15:0]
  // TS_HI   | timestamp [31:16] (32-bit timestamps only)
  // TS_LO   | timestamp [15:0]
  // LOST    | drop count, only when the entry carries one
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_ADDR_HI, S_ADDR_LO, S_TS_HI, S_TS_LO, S_LOST
  } state_t;

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [15:0] NUM_CH_VAL = 16'(NUM_CH);
  localparam logic [AW:0] FIFO_FULL  = (AW+1)'(FIFO_DEPTH);

  logic               gctrl_en;
  logic [NUM_CH-1:0]  ch_en;
  logic [31:0]        ch_lo [NUM_CH];
  logic [31:0]        ch_hi [NUM_CH];
  logic [15:0]        drop_cnt;
  logic [TS_WIDTH-1:0] ts;

  logic               cap_valid;
  logic [31:0]        cap_addr;
  logic [TS_WIDTH-1:0] cap_ts;

  logic [3:0]         fifo_ch   [FIFO_DEPTH];
  logic [31:0]        fifo_addr [FIFO_DEPTH];
  logic [TS_WIDTH-1:0] fifo_ts  [FIFO_DEPTH];
  logic [15:0]        fifo_drop [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count, count_next;

  logic               match_hit;
  logic [3:0]         match_ch;
  logic               push, pop, drop, last_flit, lost;
  logic [31:0]        head_ts32;
  state_t             state, state_next;

  // ---------------- register access ----------------
  logic [15:0] reg_off;
  logic [3:0]  reg_ch;
  logic [2:0]  reg_field;
  logic        in_ch_range, ch_acc, hit, ro, reg_wr;
  logic [15:0] rd_val;

  assign reg_off     = reg_addr - 16'h0210;
  assign reg_ch      = reg_off[6:3];
  assign reg_field   = reg_off[2:0];
  assign in_ch_range = (reg_addr >= 16'h0210) && (reg_off < 16'(8 * NUM_CH));
  assign ch_acc      = in_ch_range && (reg_field <= 3'd4);

  always_comb begin
    rd_val = '0;
    hit    = 1'b0;
    ro     = 1'b0;
    if (reg_addr == 16'h0200) begin
      hit    = 1'b1;
      rd_val = {15'b0, gctrl_en};
    end else if (reg_addr == 16'h0201) begin
      hit    = 1'b1;
      ro     = 1'b1;
      rd_val = NUM_CH_VAL;
    end else if (reg_addr == 16'h0202) begin
      hit    = 1'b1;
      ro     = 1'b1;
      rd_val = drop_cnt;
    end else if (ch_acc) begin
      hit = 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (reg_ch == 4'(c)) begin
          case (reg_field)
            3'd0:    rd_val = {15'b0, ch_en[c]};
            3'd1:    rd_val = ch_lo[c][31:16];
            3'd2:    rd_val = ch_lo[c][15:0];
            3'd3:    rd_val = ch_hi[c][31:16];
            3'd4:    rd_val = ch_hi[c][15:0];
            default: rd_val = '0;
          endcase
        end
      end
    end
  end

  assign reg_ack   = reg_request;
  assign reg_err   = reg_request & (~hit | (reg_write & ro));
  assign reg_rdata = (reg_request & ~reg_write & ~reg_err) ? rd_val : '0;
  assign reg_wr    = reg_request & reg_write & ~reg_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gctrl_en <= 1'b0;
      ch_en    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        ch_lo[c] <= '0;
        ch_hi[c] <= '0;
      end
    end else if (reg_wr) begin
      if (reg_addr == 16'h0200) begin
        gctrl_en <= reg_wdata[0];
      end else if (ch_acc) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (reg_ch == 4'(c)) begin
            case (reg_field)
              3'd0:    ch_en[c]        <= reg_wdata[0];
              3'd1:    ch_lo[c][31:16] <= reg_wdata;
              3'd2:    ch_lo[c][15:0]  <= reg_wdata;
              3'd3:    ch_hi[c][31:16] <= reg_wdata;
              3'd4:    ch_hi[c][15:0]  <= reg_wdata;
              default: ;
            endcase
          end
        end
      end
    end
  end

  // ---------------- capture and match ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts        <= '0;
      cap_valid <= 1'b0;
      cap_addr  <= '0;
      cap_ts    <= '0;
    end else begin
      ts        <= ts + 1'b1;
      cap_valid <= mem_valid & mem_we & gctrl_en;
      cap_addr  <= mem_addr;
      cap_ts    <= ts;
    end
  end

  // Descending scan so the lowest-index matching channel wins.
  always_comb begin
    match_hit = 1'b0;
    match_ch  = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (cap_valid && ch_en[c] && (ch_lo[c] <= cap_addr) && (cap_addr <= ch_hi[c])) begin
        match_hit = 1'b1;
        match_ch  = 4'(c);
      end
    end
  end

  // ---------------- event FIFO ----------------
  assign push = match_hit & ((count != FIFO_FULL) | pop);
  assign drop = match_hit & ~push;

  always_comb begin
    count_next = count;
    if (push & ~pop)
      count_next = count + 1'b1;
    else if (pop & ~push)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_ch[wr_ptr]   <= match_ch;
      fifo_addr[wr_ptr] <= cap_addr;
      fifo_ts[wr_ptr]   <= cap_ts;
      fifo_drop[wr_ptr] <= drop_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      if (push)
        drop_cnt <= '0;
      else if (drop && (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // ---------------- serialiser ----------------
  assign lost      = (fifo_drop[rd_ptr] != 16'd0);
  assign head_ts32 = 32'(fifo_ts[rd_ptr]);
  assign out_valid = (state != S_IDLE);
  assign last_flit = (state == S_LOST) | ((state == S_TS_LO) & ~lost);
  assign out_last  = last_flit;
  assign pop       = out_valid & out_ready & last_flit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    out_data   = '0;
    case (state)
      S_IDLE: begin
        if (count_next != '0) state_next = S_HDR;
      end
      S_HDR: begin
        out_data = {lost, 11'b0, fifo_ch[rd_ptr]};
        if (out_ready) state_next = S_ADDR_HI;
      end
      S_ADDR_HI: begin
        out_data = fifo_addr[rd_ptr][31:16];
        if (out_ready) state_next = S_ADDR_LO;
      end
      S_ADDR_LO: begin
        out_data = fifo_addr[rd_ptr][15:0];
        if (out_ready) state_next = (TS_WIDTH == 32) ? S_TS_HI : S_TS_LO;
      end
      S_TS_HI: begin
        out_data = head_ts32[31:16];
        if (out_ready) state_next = S_TS_LO;
      end
      S_TS_LO: begin
        out_data = head_ts32[15:0];
        if (out_ready) begin
          if (lost)                    state_next = S_LOST;
          else if (count_next != '0)   state_next = S_HDR;
          else                         state_next = S_IDLE;
        end
      end
      S_LOST: begin
        out_data = fifo_drop[rd_ptr];
        if (out_ready) state_next = (count_next != '0) ? S_HDR : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule
